// File: rtl/xor_reduce_pipe_pkg.sv
// ---------------------------------------------------------------------------
// xor_reduce_pkg
//   Shared defaults and elaboration-time helpers for the pipelined XOR
//   reduction fabric (xor_reduce_pipe) and the PAR wrapper top-levels that
//   instantiate it.
//
//   Optional feature macro: PARITY_ACCUM_EN (adds the ones-counter default).
//
//   Helpers:
//     clog_k(n,k)               number of k-input XOR levels needed to fold n
//                               bits to one, never less than one level.
//     stage_width(s,width,k)    bits left after stage s (s counts from 0).
//     stage_offset(s,width,k)   bit offset of stage s outputs inside the packed
//                               per-channel chain vector used by the top.
// ---------------------------------------------------------------------------
package xor_reduce_pkg;

  localparam int DEF_WIDTH    = 3;
  localparam int DEF_CHANNELS = 1;
  localparam int DEF_LUT_K    = 4;
`ifdef PARITY_ACCUM_EN
  localparam int DEF_CNT_W    = 16;
`endif

  function automatic int clog_k(int n, int k);
    int w = n;
    int s = 0;
    while (w > 1) begin
      w = (w + k - 1) / k;
      s++;
    end
    // A single bit still gets one register so WIDTH=1 is a registered XOR.
    return (s < 1) ? 1 : s;
  endfunction

  function automatic int stage_width(int s, int width, int k);
    int w = width;
    for (int i = 0; i <= s; i++) begin
      w = (w + k - 1) / k;
    end
    return w;
  endfunction

  function automatic int stage_offset(int s, int width, int k);
    int off = 0;
    for (int i = 0; i < s; i++) begin
      off += stage_width(i, width, k);
    end
    return off;
  endfunction

endpackage

// File: rtl/xor_reduce_pipe_if.sv
// ---------------------------------------------------------------------------
// xor_reduce_pipe_if
//   Data/handshake bundle of the XOR reduction pipeline.
//
//   Optional feature macro: PARITY_ACCUM_EN (adds acc_clr/acc_out/ones_cnt).
//
//   Signals:
//     en        pipeline advance, 0 = every stage holds
//     in_valid  qualifier for in_data/invert
//     in_data   CHANNELS*WIDTH, channel c = in_data[c*WIDTH +: WIDTH]
//     invert    per-channel XNOR select
//     out_valid qualifier for out_data
//     out_data  per-channel parity
//     acc_clr   synchronous accumulator clear         (PARITY_ACCUM_EN)
//     acc_out   running parity of accepted out_data   (PARITY_ACCUM_EN)
//     ones_cnt  saturating count of out_data[0]==1    (PARITY_ACCUM_EN)
//
//   Modports: master drives the inputs (test driver / pins), slave is the
//   reduction pipeline.
// ---------------------------------------------------------------------------
interface xor_reduce_pipe_if
  import xor_reduce_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS
`ifdef PARITY_ACCUM_EN
  ,
  parameter int CNT_W    = DEF_CNT_W
`endif
);

  logic                      en;
  logic                      in_valid;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       invert;
  logic                      out_valid;
  logic [CHANNELS-1:0]       out_data;
`ifdef PARITY_ACCUM_EN
  logic                      acc_clr;
  logic [CHANNELS-1:0]       acc_out;
  logic [CNT_W-1:0]          ones_cnt;
`endif

  modport master (
`ifdef PARITY_ACCUM_EN
    output acc_clr,
    input  acc_out,
    input  ones_cnt,
`endif
    output en,
    output in_valid,
    output in_data,
    output invert,
    input  out_valid,
    input  out_data
  );

  modport slave (
`ifdef PARITY_ACCUM_EN
    input  acc_clr,
    output acc_out,
    output ones_cnt,
`endif
    input  en,
    input  in_valid,
    input  in_data,
    input  invert,
    output out_valid,
    output out_data
  );

endinterface

// File: rtl/xor_reduce_pipe_stage.sv
// ---------------------------------------------------------------------------
// xor_tree_stage
//   One registered level of the XOR reduction tree. Input bit i lands in
//   group i/LUT_K, so groups are LUT_K wide except a possibly shorter last
//   group; nothing is zero-padded into a wider LUT.
//   i_flip is folded into output bit 0; the top ties it low on every level
//   except the last, where it carries the per-channel invert.
//
//   Ports:
//     gclk    clock
//     reset   async active-high reset, clears o_q
//     i_en    load enable, 0 = hold
//     i_d     IN_W bits from the previous level (or the pins)
//     i_flip  extra XOR term for output bit 0
//     o_q     ceil(IN_W/LUT_K) registered group parities
// ---------------------------------------------------------------------------
module xor_tree_stage #(
  parameter int IN_W  = 4,
  parameter int LUT_K = 4
) (
  input  logic                              gclk,
  input  logic                              reset,
  input  logic                              i_en,
  input  logic [IN_W-1:0]                   i_d,
  input  logic                              i_flip,
  output logic [(IN_W+LUT_K-1)/LUT_K-1:0]   o_q
);

  localparam int OUT_W = (IN_W + LUT_K - 1) / LUT_K;

  logic [OUT_W-1:0] w_red;
  logic [OUT_W-1:0] r_q;

  always_comb begin
    w_red = '0;
    for (int i = 0; i < IN_W; i++) begin
      w_red[i/LUT_K] = w_red[i/LUT_K] ^ i_d[i];
    end
    w_red[0] = w_red[0] ^ i_flip;
  end

  always_ff @(posedge gclk or posedge reset) begin
    if (reset) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= w_red;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/xor_reduce_pipe.sv
// ---------------------------------------------------------------------------
// xor_reduce_pipe
//   Reduces CHANNELS independent WIDTH-bit vectors to one parity bit each
//   through STAGES = max(1, ceil(log_LUT_K(WIDTH))) registered XOR levels.
//   A valid shift chain and an invert shift chain run beside the data; the
//   invert bit joins the XOR at the last level. Data registers load on every
//   enabled cycle regardless of valid so the LUT mapping stays flat.
//   With WIDTH=3, LUT_K=4 this is the legacy single registered 3-input XOR.
//
//   Optional feature macro: PARITY_ACCUM_EN
//     Adds per-channel running parity (acc_out) and a saturating ones
//     counter on channel 0 (ones_cnt), both updated on en & out_valid and
//     cleared synchronously by acc_clr (not gated by en, wins over update).
//
//   Ports:
//     gclk   clock, all logic on posedge
//     reset  async active-high reset, flushes every register
//     bus    xor_reduce_pipe_if.slave (en, in_valid, in_data, invert,
//            out_valid, out_data [, acc_clr, acc_out, ones_cnt])
// ---------------------------------------------------------------------------
module xor_reduce_pipe
  import xor_reduce_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int LUT_K    = DEF_LUT_K
`ifdef PARITY_ACCUM_EN
  ,
  parameter int CNT_W    = DEF_CNT_W
`endif
) (
  input  logic            gclk,
  input  logic            reset,
  xor_reduce_pipe_if.slave bus
);

  localparam int STAGES = clog_k(WIDTH, LUT_K);
  // All level outputs of one channel packed back to back, level 0 first.
  localparam int CHAIN_W = stage_offset(STAGES, WIDTH, LUT_K);
  localparam int LAST_OFF = stage_offset(STAGES - 1, WIDTH, LUT_K);

  logic [STAGES-1:0]                 r_vld;
  logic [CHANNELS-1:0]               w_inv_last;
  logic [CHANNELS-1:0][CHAIN_W-1:0]  w_chain;
  logic [CHANNELS-1:0]               w_par;

  // Valid sideband
  always_ff @(posedge gclk or posedge reset) begin
    if (reset) begin
      r_vld <= '0;
    end else if (bus.en) begin
      r_vld[0] <= bus.in_valid;
      for (int s = 1; s < STAGES; s++) begin
        r_vld[s] <= r_vld[s-1];
      end
    end
  end

  // Invert sideband: delayed STAGES-1 levels so it meets its own data at
  // the final XOR level.
  if (STAGES == 1) begin : g_inv_direct
    assign w_inv_last = bus.invert;
  end else begin : g_inv_chain
    logic [CHANNELS-1:0] r_inv [STAGES-1];

    always_ff @(posedge gclk or posedge reset) begin
      if (reset) begin
        for (int s = 0; s < STAGES - 1; s++) begin
          r_inv[s] <= '0;
        end
      end else if (bus.en) begin
        r_inv[0] <= bus.invert;
        for (int s = 1; s < STAGES - 1; s++) begin
          r_inv[s] <= r_inv[s-1];
        end
      end
    end

    assign w_inv_last = r_inv[STAGES-2];
  end

  // Reduction tree, one chain of levels per channel
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    for (genvar s = 0; s < STAGES; s++) begin : g_st
      localparam int IN_W    = (s == 0) ? WIDTH : stage_width(s - 1, WIDTH, LUT_K);
      localparam int OUT_W   = stage_width(s, WIDTH, LUT_K);
      localparam int OUT_OFF = stage_offset(s, WIDTH, LUT_K);
      localparam int IN_OFF  = (s == 0) ? 0 : stage_offset(s - 1, WIDTH, LUT_K);

      logic [IN_W-1:0] w_d;
      logic            w_flip;

      if (s == 0) begin : g_src_pins
        assign w_d = bus.in_data[c*WIDTH +: WIDTH];
      end else begin : g_src_prev
        assign w_d = w_chain[c][IN_OFF +: IN_W];
      end

      if (s == STAGES - 1) begin : g_flip_last
        assign w_flip = w_inv_last[c];
      end else begin : g_flip_none
        assign w_flip = 1'b0;
      end

      xor_tree_stage #(
        .IN_W  (IN_W),
        .LUT_K (LUT_K)
      ) u_stage (
        .gclk   (gclk),
        .reset  (reset),
        .i_en   (bus.en),
        .i_d    (w_d),
        .i_flip (w_flip),
        .o_q    (w_chain[c][OUT_OFF +: OUT_W])
      );
    end

    assign w_par[c] = w_chain[c][LAST_OFF];
  end

  assign bus.out_valid = r_vld[STAGES-1];
  assign bus.out_data  = w_par;

`ifdef PARITY_ACCUM_EN
  logic [CHANNELS-1:0] r_acc;
  logic [CNT_W-1:0]    r_cnt;

  always_ff @(posedge gclk or posedge reset) begin
    if (reset) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (bus.acc_clr) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (bus.en && r_vld[STAGES-1]) begin
      r_acc <= r_acc ^ w_par;
      if (w_par[0] && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign bus.acc_out  = r_acc;
  assign bus.ones_cnt = r_cnt;
`endif

endmodule
